// File: rtl/msg_pkg.sv
// Shared constants, FSM encoding and charset stepping for the message composer.
package msg_pkg;

   localparam logic [7:0] CH_A    = 8'd65;
   localparam logic [7:0] CH_Z    = 8'd90;
   localparam logic [7:0] CH_0    = 8'd48;
   localparam logic [7:0] CH_9    = 8'd57;
   localparam logic [7:0] CH_BANG = 8'd33;
   localparam logic [7:0] CH_CR   = 8'h0D;
   localparam logic [7:0] CH_LF   = 8'h0A;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_LO,
      ST_WAIT_HI
   } tx_state_e;

   // Ring order A..Z, 0..9, '!', back to A; anything off the ring lands on 'A'.
   function automatic logic [7:0] char_next(input logic [7:0] c);
      logic [7:0] r;
      if (c >= CH_A && c < CH_Z)      r = c + 8'd1;
      else if (c == CH_Z)             r = CH_0;
      else if (c >= CH_0 && c < CH_9) r = c + 8'd1;
      else if (c == CH_9)             r = CH_BANG;
      else                            r = CH_A;
      return r;
   endfunction

   // Exact inverse of char_next; anything off the ring lands on '!'.
   function automatic logic [7:0] char_prev(input logic [7:0] c);
      logic [7:0] r;
      if (c > CH_A && c <= CH_Z)      r = c - 8'd1;
      else if (c == CH_A)             r = CH_BANG;
      else if (c > CH_0 && c <= CH_9) r = c - 8'd1;
      else if (c == CH_0)             r = CH_Z;
      else if (c == CH_BANG)          r = CH_9;
      else                            r = CH_BANG;
      return r;
   endfunction

endpackage

// File: rtl/msg_tx_seq.sv
// Streams buf[0..last] (plus optional CR/LF) into uart_tx using its ready/send handshake.
module msg_tx_seq
   import msg_pkg::*;
#(
   parameter int AW          = 4,
   parameter bit APPEND_CRLF = 1'b1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] start_last,
   input  logic          tx_ready,
   output logic [AW-1:0] rd_addr,
   input  logic [7:0]    rd_data,
   output logic          tx_send,
   output logic [7:0]    tx_data,
   output logic          busy
);

   // One extra index bit so the CR/LF positions past a full buffer are reachable.
   localparam int            IW   = AW + 1;
   localparam logic [IW-1:0] TAIL = APPEND_CRLF ? IW'(2) : IW'(0);

   tx_state_e     state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [AW-1:0] last_q, last_d;
   logic [IW-1:0] last_ext, final_idx;
   logic          send_d;
   logic [7:0]    data_d, byte_sel;

   assign last_ext  = {1'b0, last_q};
   assign final_idx = last_ext + TAIL;
   assign rd_addr   = idx_q[AW-1:0];
   assign busy      = (state_q != ST_IDLE);

   // Pick the byte for the current index: buffer cell, then CR, then LF.
   always_comb begin
      byte_sel = rd_data;
      if (idx_q > last_ext) begin
         byte_sel = (idx_q == last_ext + IW'(1)) ? CH_CR : CH_LF;
      end
   end

   // Next-state and handshake decisions; the strobe is registered so it lasts one cycle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      send_d  = 1'b0;
      data_d  = tx_data;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               last_d  = start_last;
               idx_d   = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (tx_ready) begin
               send_d  = 1'b1;
               data_d  = byte_sel;
               state_d = ST_WAIT_LO;
            end
         end
         ST_WAIT_LO: begin
            if (!tx_ready) state_d = ST_WAIT_HI;
         end
         ST_WAIT_HI: begin
            if (tx_ready) begin
               if (idx_q == final_idx) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = ST_ISSUE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, counters and the uart-facing outputs; reset aborts any transfer immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         last_q  <= '0;
         tx_send <= 1'b0;
         tx_data <= 8'h00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         tx_send <= send_d;
         tx_data <= data_d;
      end
   end

endmodule

// File: rtl/msg_compose_tx.sv
// Button-driven message editor: buffer, cursor and edit gating around the transmit sequencer.
module msg_compose_tx
   import msg_pkg::*;
#(
   parameter int         DEPTH       = 16,
   parameter bit         APPEND_CRLF = 1'b1,
   parameter logic [7:0] CHAR_INIT   = 8'd65,
   localparam int        AW          = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          dec,
   input  logic          fwd,
   input  logic          back,
   input  logic          send_req,
   input  logic          tx_ready,
   output logic          tx_send,
   output logic [7:0]    tx_data,
   output logic [7:0]    cur_char,
   output logic [AW-1:0] cursor,
   output logic          busy
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_addr;
   logic          start;

   assign cur_char = mem[cursor];
   assign start    = send_req && !busy;

   // Edits and cursor moves only while idle, which also freezes the buffer during a send.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= CHAR_INIT;
         cursor <= '0;
      end else if (!busy) begin
         if (inc && !dec)      mem[cursor] <= char_next(mem[cursor]);
         else if (dec && !inc) mem[cursor] <= char_prev(mem[cursor]);
         if (fwd && !back && cursor != AW'(DEPTH - 1)) cursor <= cursor + AW'(1);
         else if (back && !fwd && cursor != '0)        cursor <= cursor - AW'(1);
      end
   end

   msg_tx_seq #(
      .AW          (AW),
      .APPEND_CRLF (APPEND_CRLF)
   ) u_seq (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_last (cursor),
      .tx_ready   (tx_ready),
      .rd_addr    (rd_addr),
      .rd_data    (mem[rd_addr]),
      .tx_send    (tx_send),
      .tx_data    (tx_data),
      .busy       (busy)
   );

endmodule

// File: tb/tb_msg_compose_tx.sv
// Scoreboard bench for msg_compose_tx with a simple uart_tx ready model.
module tb_msg_compose_tx;

   logic       clk = 1'b0;
   logic       rst, inc, dec, fwd, back, send_req;
   logic       tx_ready = 1'b1;
   logic       tx_send, busy;
   logic [7:0] tx_data, cur_char;
   logic [3:0] cursor;

   logic [7:0] exp_q[$];
   int         n_checks   = 0;
   int         n_fail     = 0;
   int         strobe_cnt = 0;
   int         uart_cnt   = 0;
   logic       hold_low   = 1'b0;
   logic       prev_send  = 1'b0;

   msg_compose_tx #(
      .DEPTH       (16),
      .APPEND_CRLF (1'b1),
      .CHAR_INIT   (8'd65)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc),
      .dec      (dec),
      .fwd      (fwd),
      .back     (back),
      .send_req (send_req),
      .tx_ready (tx_ready),
      .tx_send  (tx_send),
      .tx_data  (tx_data),
      .cur_char (cur_char),
      .cursor   (cursor),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // uart_tx stand-in: takes a byte on send while ready, then stays busy for 10 cycles.
   always @(posedge clk) begin
      if (tx_send && tx_ready) begin
         tx_ready <= 1'b0;
         uart_cnt <= 10;
      end else begin
         if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
         tx_ready <= (uart_cnt <= 1) && !hold_low;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic i, input logic d, input logic f, input logic b, input logic s);
      inc = i; dec = d; fwd = f; back = b; send_req = s;
      @(posedge clk); #1;
      inc = 0; dec = 0; fwd = 0; back = 0; send_req = 0;
   endtask

   task automatic waitIdle();
      for (int c = 0; c < 2000 && busy; c++) begin
         @(posedge clk); #1;
      end
      checkOutput("busy_timeout", busy, 0);
   endtask

   task automatic pushMsg(input logic [7:0] b0, input logic [7:0] b1);
      exp_q.push_back(b0);
      exp_q.push_back(b1);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   // Monitor: every strobe pops the scoreboard and checks the handshake rules.
   always @(negedge clk) begin
      if (tx_send) begin
         strobe_cnt++;
         checkOutput("ready_at_strobe", tx_ready, 1);
         checkOutput("single_cycle_strobe", prev_send, 0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_strobe: got byte 0x%0h, expected no strobe at %0t", tx_data, $time);
         end else begin
            checkOutput("tx_byte", tx_data, exp_q.pop_front());
         end
      end
      prev_send = tx_send;
   end

   initial begin
      rst = 1; inc = 0; dec = 0; fwd = 0; back = 0; send_req = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_cur_char", cur_char, 65);
      checkOutput("rst_cursor", cursor, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_tx_send", tx_send, 0);
      checkOutput("rst_tx_data", tx_data, 0);
      rst = 0;

      // charset ring walking
      repeat (3) applyStimulus(1, 0, 0, 0, 0);
      checkOutput("inc3", cur_char, 68);
      repeat (4) applyStimulus(0, 1, 0, 0, 0);
      checkOutput("dec4_wrap_bang", cur_char, 33);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("bang_next_A", cur_char, 65);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("A_prev_bang", cur_char, 33);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("bang_prev_9", cur_char, 57);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("9_next_bang", cur_char, 33);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("bang_next_A2", cur_char, 65);
      repeat (25) applyStimulus(1, 0, 0, 0, 0);
      checkOutput("inc25_Z", cur_char, 90);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("Z_next_0", cur_char, 48);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("0_prev_Z", cur_char, 90);
      repeat (25) applyStimulus(0, 1, 0, 0, 0);
      checkOutput("dec25_A", cur_char, 65);

      // cursor saturation and simultaneous pulses
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("back_sat0", cursor, 0);
      repeat (19) applyStimulus(0, 0, 1, 0, 0);
      checkOutput("fwd_sat15", cursor, 15);
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("inc_dec_hold", cur_char, 65);
      applyStimulus(0, 0, 1, 1, 0);
      checkOutput("fwd_back_hold", cursor, 15);
      applyStimulus(1, 0, 0, 1, 0);
      checkOutput("edit_move_cursor", cursor, 14);
      checkOutput("edit_move_newcell", cur_char, 65);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("edit_old_cell", cur_char, 66);
      repeat (15) applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("AB_cursor", cursor, 1);
      checkOutput("AB_cell1", cur_char, 66);

      // first transfer of "AB\r\n" with ignored pulses while busy
      pushMsg(8'h41, 8'h42);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("busy_rise", busy, 1);
      repeat (15) begin @(posedge clk); #1; end
      applyStimulus(1, 0, 1, 0, 1);
      waitIdle();
      checkOutput("strobes_first", strobe_cnt, 4);
      checkOutput("queue_first", exp_q.size(), 0);
      checkOutput("tx_data_hold", tx_data, 8'h0A);
      checkOutput("frozen_cursor", cursor, 1);
      checkOutput("frozen_cell1", cur_char, 66);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("frozen_cell0", cur_char, 65);
      applyStimulus(0, 0, 1, 0, 0);

      // second identical transfer
      pushMsg(8'h41, 8'h42);
      applyStimulus(0, 0, 0, 0, 1);
      waitIdle();
      checkOutput("strobes_second", strobe_cnt, 8);
      checkOutput("queue_second", exp_q.size(), 0);

      // reset after the 2nd strobe of a third transfer
      pushMsg(8'h41, 8'h42);
      applyStimulus(0, 0, 0, 0, 1);
      for (int c = 0; c < 2000 && strobe_cnt < 10; c++) begin
         @(posedge clk); #1;
      end
      checkOutput("strobe2_timeout", strobe_cnt, 10);
      rst = 1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_cursor", cursor, 0);
      checkOutput("abort_cell0", cur_char, 65);
      checkOutput("abort_tx_send", tx_send, 0);
      repeat (40) begin @(posedge clk); #1; end
      checkOutput("abort_no_strobe", strobe_cnt, 10);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("abort_cell1", cur_char, 65);

      // tx_ready held low at send_req
      hold_low = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      pushMsg(8'h41, 8'h41);
      applyStimulus(0, 0, 0, 0, 1);
      repeat (30) begin @(posedge clk); #1; end
      checkOutput("held_no_strobe", strobe_cnt, 10);
      checkOutput("held_busy", busy, 1);
      hold_low = 1'b0;
      waitIdle();
      checkOutput("strobes_held", strobe_cnt, 14);
      checkOutput("queue_held", exp_q.size(), 0);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
